multi_nch_disp_scan: RTL and testbench
======================================

Name: multi_nch_disp_scan

Overview:
- Parametrised N-channel display-source multiplexer with registered outputs; sits between CPU/test data sources and the seven-segment display driver.
- Channel 0 is a CPU-latched register loaded on EN. Channels 1..CH-1 are live test inputs.
- Channel selection is either manual (Test selector) or automatic round-robin scan on a programmable period.
- Per-channel blink and point masks follow the selected channel.

Parameters:
- CH, 8, channel count (2..16).
- DW, 32, display data width.
- MW, 8, blink/point mask width per channel.
- SW, 3, selector width; must satisfy 2^SW >= CH.
- SCAN_DIV, 50000000, clock cycles per channel in auto mode (>=1).
- RST_DATA, 32'hAA5555AA, reset value of channel-0 data register (DW bits).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- EN  in  1  load channel-0 registers from Data0, LES[MW-1:0], point_in[MW-1:0].
- auto  in  1  1 = auto-scan mode, 0 = manual mode.
- freeze  in  1  hold all output registers and scan state.
- Test  in  SW  manual channel selector.
- Data0  in  DW  CPU data for channel 0.
- Test_data  in  (CH-1)*DW  channel k (k>=1) at bits [k*DW-1:(k-1)*DW].
- LES  in  CH*MW  blink mask; channel k at [(k+1)*MW-1:k*MW].
- point_in  in  CH*MW  point mask; same packing as LES.
- Disp_num  out  DW  selected display data (registered).
- blink_out  out  MW  selected blink mask (registered).
- point_out  out  MW  selected point mask (registered).
- cur_ch  out  SW  channel currently driving outputs (registered).
- ch_tick  out  1  one-cycle pulse on each auto-scan channel advance.

Behaviour:
- Reset (rst==0 at edge):
  - ch0_data=RST_DATA, ch0_blink=all 1, ch0_point=0.
  - State MANUAL, scan counter=0, sel=0.
  - Disp_num=RST_DATA, blink_out=all 1, point_out=0, cur_ch=0, ch_tick=0.
  - Reset overrides EN, auto and freeze, including mid-scan.
- Channel-0 capture:
  - If EN at edge k, ch0 registers load at edge k; otherwise they hold.
  - EN is independent of freeze and mode.
  - With channel 0 selected, the new value appears on the outputs at edge k+1.
- Output path:
  - At each edge (freeze=0), outputs load mux(sel) of the current channel sources.
  - Latency is 1 cycle from a live input or from a sel change.
  - cur_ch is updated with the same edge as the data it labels.
- Selection:
  - MANUAL: sel = Test if Test < CH, else 0 (out-of-range clamps to channel 0).
- State machine, 2 states:
  - MANUAL -> AUTO when auto==1. The scan starts from the current sel, with the counter cleared to 0.
  - AUTO -> MANUAL when auto==0. sel takes Test on that same edge; the counter is cleared.
- Scan counter in AUTO:
  - Counts 0..SCAN_DIV-1.
  - At terminal count, counter goes to 0 and sel goes to sel+1, wrapping CH-1 -> 0. ch_tick=1 for exactly that cycle, registered alongside the new cur_ch.
  - SCAN_DIV=1 advances every cycle.
- freeze=1:
  - Outputs, sel, counter and state hold; ch_tick=0.
  - Mode changes are deferred until freeze drops.
  - ch0 capture still operates.
- Simultaneous events:
  - EN together with a terminal count: both take effect.
  - Terminal count together with auto dropping: the MANUAL transition wins and no tick is issued.
- No combinational path from any input to any output.

Test Plan:
- Reset with rst=0 for 2 cycles -> Disp_num=32'hAA5555AA, blink_out=8'hFF, point_out=8'h00, cur_ch=0.
- Manual mode, Test=3, Test_data ch3=32'h12345678, LES[31:24]=8'h0F, point_in[31:24]=8'hA0 -> one cycle later Disp_num=32'h12345678, blink_out=8'h0F, point_out=8'hA0, cur_ch=3.
- Test=0, then EN pulse with Data0=32'hDEADBEEF -> Disp_num=32'hDEADBEEF two edges after EN and held after EN drops. Repeat with freeze=1: Disp_num unchanged until freeze falls.
- SCAN_DIV=4, CH=8, auto=1 from sel=6 -> cur_ch sequence 6,7,0,1 at 4-cycle intervals, ch_tick high exactly one cycle at each change.
- CH=5 build, manual Test=6 -> cur_ch=0, Disp_num=channel-0 data.
- In auto mode, assert rst=0 when counter=2 -> next edge all reset values and state MANUAL. Separately, drop auto on a terminal-count cycle -> cur_ch=Test and no ch_tick.

Source files
------------

// File: rtl/multi_nch_disp_scan.sv
// multi_nch_disp_scan: N-channel display-source multiplexer feeding the
// seven-segment driver. Channel 0 is a CPU-loaded register; channels 1..CH-1
// are live test inputs. The channel is chosen manually or by a round-robin
// scan. Data, blink mask and point mask are all registered at the outputs.
module multi_nch_disp_scan #(
  parameter int              CH       = 8,
  parameter int              DW       = 32,
  parameter int              MW       = 8,
  parameter int              SW       = 3,
  parameter int              SCAN_DIV = 50000000,
  parameter logic [DW-1:0]   RST_DATA = 32'hAA5555AA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EN,
  input  logic                 auto,
  input  logic                 freeze,
  input  logic [SW-1:0]        Test,
  input  logic [DW-1:0]        Data0,
  input  logic [(CH-1)*DW-1:0] Test_data,
  input  logic [CH*MW-1:0]     LES,
  input  logic [CH*MW-1:0]     point_in,
  output logic [DW-1:0]        Disp_num,
  output logic [MW-1:0]        blink_out,
  output logic [MW-1:0]        point_out,
  output logic [SW-1:0]        cur_ch,
  output logic                 ch_tick
);

  // Scan counter width; a divider of 1 still needs a 1-bit counter.
  localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(CH - 1);

  typedef enum logic {MANUAL, AUTO} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [SW-1:0]   sel_nxt;
  logic [SW-1:0]   test_sel;
  logic            tick_nxt;

  logic [DW-1:0]   ch0_data;
  logic [MW-1:0]   ch0_blink;
  logic [MW-1:0]   ch0_point;

  logic [DW-1:0]   src_data  [CH];
  logic [MW-1:0]   src_blink [CH];
  logic [MW-1:0]   src_point [CH];
  logic [DW-1:0]   mux_data;
  logic [MW-1:0]   mux_blink;
  logic [MW-1:0]   mux_point;

  // Channel-0 capture runs regardless of mode or freeze.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    if (!rst) begin
      ch0_data  <= RST_DATA;
      ch0_blink <= '1;
      ch0_point <= '0;
    end else if (EN) begin
      ch0_data  <= Data0;
      ch0_blink <= LES[MW-1:0];
      ch0_point <= point_in[MW-1:0];
    end
  end

  // Manual selector with out-of-range values folded onto channel 0.
  assign test_sel = (32'(Test) < CH) ? Test : '0;

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= MANUAL;
    else      state <= state_nxt;
  end

  // Next-state, next-channel, counter and tick decode.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    sel_nxt   = cur_ch;
    cnt_nxt   = cnt;
    tick_nxt  = 1'b0;
    if (!freeze) begin
      case (state)
        MANUAL: begin
          if (auto) begin
            // Scan resumes from whatever channel is already on display.
            state_nxt = AUTO;
            cnt_nxt   = '0;
          end else begin
            sel_nxt   = test_sel;
          end
        end
        AUTO: begin
          if (!auto) begin
            // Leaving auto wins over a coincident terminal count.
            state_nxt = MANUAL;
            sel_nxt   = test_sel;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            sel_nxt   = (cur_ch == CH_LAST) ? '0 : cur_ch + SW'(1);
            tick_nxt  = 1'b1;
          end else begin
            cnt_nxt   = cnt + CW'(1);
          end
        end
        default: state_nxt = MANUAL;
      endcase
    end
  end

  // Per-channel source tables and the selector mux for the next channel.
  always_comb begin
    src_data[0]  = ch0_data;
    src_blink[0] = ch0_blink;
    src_point[0] = ch0_point;
    for (int k = 1; k < CH; k++) begin
      src_data[k]  = Test_data[(k-1)*DW +: DW];
      src_blink[k] = LES[k*MW +: MW];
      src_point[k] = point_in[k*MW +: MW];
    end
    mux_data  = '0;
    mux_blink = '0;
    mux_point = '0;
    for (int k = 0; k < CH; k++) begin
      if (sel_nxt == SW'(k)) begin
        mux_data  = src_data[k];
        mux_blink = src_blink[k];
        mux_point = src_point[k];
      end
    end
  end

  // Scan counter and output registers; freeze holds everything but the tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      cur_ch    <= '0;
      Disp_num  <= RST_DATA;
      blink_out <= '1;
      point_out <= '0;
      ch_tick   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      ch_tick <= tick_nxt;
      if (!freeze) begin
        cur_ch    <= sel_nxt;
        Disp_num  <= mux_data;
        blink_out <= mux_blink;
        point_out <= mux_point;
      end
    end
  end

endmodule

// File: tb/tb_multi_nch_disp_scan.sv
// Testbench for multi_nch_disp_scan: an 8-channel scanning instance and a
// 5-channel instance for selector clamping. Stimulus pushes expected output
// records into a queue; a negedge monitor pops and compares them.
module tb_multi_nch_disp_scan;

  typedef struct {
    int          cyc;
    int          vec;
    bit          id;
    logic [31:0] disp;
    logic [7:0]  blink;
    logic [7:0]  point;
    logic [2:0]  ch;
    logic        tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   vec    = 0;

  logic clk = 1'b0;
  logic rst;

  // 8-channel instance, SCAN_DIV = 4
  logic         en, auto_m, freeze;
  logic [2:0]   test;
  logic [31:0]  data0;
  logic [223:0] test_data;
  logic [63:0]  les, pnt;
  logic [31:0]  disp;
  logic [7:0]   blink, point;
  logic [2:0]   cur_ch;
  logic         tick;

  // 5-channel instance, manual only
  logic         zero5 = 1'b0;
  logic [31:0]  data0_5 = '0;
  logic [2:0]   test5;
  logic [127:0] test_data5;
  logic [39:0]  les5, pnt5;
  logic [31:0]  disp5;
  logic [7:0]   blink5, point5;
  logic [2:0]   cur_ch5;
  logic         tick5;

  multi_nch_disp_scan #(.CH(8), .DW(32), .MW(8), .SW(3), .SCAN_DIV(4),
                        .RST_DATA(32'hAA5555AA)) dut (
    .clk(clk), .rst(rst), .EN(en), .auto(auto_m), .freeze(freeze),
    .Test(test), .Data0(data0), .Test_data(test_data), .LES(les),
    .point_in(pnt), .Disp_num(disp), .blink_out(blink), .point_out(point),
    .cur_ch(cur_ch), .ch_tick(tick)
  );

  multi_nch_disp_scan #(.CH(5), .DW(32), .MW(8), .SW(3), .SCAN_DIV(2),
                        .RST_DATA(32'hAA5555AA)) dut5 (
    .clk(clk), .rst(rst), .EN(zero5), .auto(zero5), .freeze(zero5),
    .Test(test5), .Data0(data0_5), .Test_data(test_data5), .LES(les5),
    .point_in(pnt5), .Disp_num(disp5), .blink_out(blink5), .point_out(point5),
    .cur_ch(cur_ch5), .ch_tick(tick5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect these outputs after the edge that was just stepped over.
  task automatic expect_out(input bit id, input logic [31:0] d, input logic [7:0] b,
                            input logic [7:0] p, input logic [2:0] c, input logic t);
    exp_t e;
    e.cyc = cyc; e.vec = vec; e.id = id;
    e.disp = d; e.blink = b; e.point = p; e.ch = c; e.tick = t;
    exp_q.push_back(e);
    vec++;
  endtask

  task automatic check(input exp_t e);
    logic [31:0] d;
    logic [7:0]  b, p;
    logic [2:0]  c;
    logic        t;
    if (e.id) begin d = disp5; b = blink5; p = point5; c = cur_ch5; t = tick5; end
    else      begin d = disp;  b = blink;  p = point;  c = cur_ch;  t = tick;  end
    checks++;
    if (e.cyc != cyc) begin
      errors++;
      $display("FAIL vec%0d dut%0d: checked at cycle %0d, expected at cycle %0d",
               e.vec, e.id, cyc, e.cyc);
    end else if (d !== e.disp || b !== e.blink || p !== e.point ||
                 c !== e.ch || t !== e.tick) begin
      errors++;
      $display("FAIL vec%0d dut%0d: got disp=%h blink=%h point=%h ch=%0d tick=%b, expected disp=%h blink=%h point=%h ch=%0d tick=%b",
               e.vec, e.id, d, b, p, c, t, e.disp, e.blink, e.point, e.ch, e.tick);
    end
  endtask

  // Monitor: compare every expectation due by this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      check(exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; auto_m = 1'b0; freeze = 1'b0;
    test = 3'd0; data0 = '0; test5 = 3'd0;
    // Channel k data 0xkkkkkkkk, blink 0x1k, point 0x2k; channel 3 special.
    for (int k = 1; k < 8; k++) test_data[(k-1)*32 +: 32] = 32'h11111111 * k;
    for (int k = 0; k < 8; k++) begin
      les[k*8 +: 8] = 8'h10 + 8'(k);
      pnt[k*8 +: 8] = 8'h20 + 8'(k);
    end
    test_data[95:64] = 32'h12345678;
    les[31:24] = 8'h0F; pnt[31:24] = 8'hA0;
    les[7:0]   = 8'h3C; pnt[7:0]   = 8'h5A;
    for (int k = 1; k < 5; k++) test_data5[(k-1)*32 +: 32] = 32'h50000000 + k;
    for (int k = 0; k < 5; k++) begin
      les5[k*8 +: 8] = 8'h40 + 8'(k);
      pnt5[k*8 +: 8] = 8'h50 + 8'(k);
    end

    // Reset held two cycles.
    step(); step();
    expect_out(0, 32'hAA5555AA, 8'hFF, 8'h00, 3'd0, 1'b0);
    expect_out(1, 32'hAA5555AA, 8'hFF, 8'h00, 3'd0, 1'b0);

    // Manual selection, and CH=5 clamping of out-of-range selectors.
    rst = 1'b1; test = 3'd3; test5 = 3'd6;
    step();
    expect_out(0, 32'h12345678, 8'h0F, 8'hA0, 3'd3, 1'b0);
    expect_out(1, 32'hAA5555AA, 8'hFF, 8'h00, 3'd0, 1'b0);
    test = 3'd0; test5 = 3'd4;
    step();
    expect_out(0, 32'hAA5555AA, 8'hFF, 8'h00, 3'd0, 1'b0);
    expect_out(1, 32'h50000004, 8'h44, 8'h54, 3'd4, 1'b0);

    // Channel-0 load: visible two edges after EN rises, then held.
    test5 = 3'd5; en = 1'b1; data0 = 32'hDEADBEEF;
    step();
    expect_out(0, 32'hAA5555AA, 8'hFF, 8'h00, 3'd0, 1'b0);
    expect_out(1, 32'hAA5555AA, 8'hFF, 8'h00, 3'd0, 1'b0);
    en = 1'b0; data0 = 32'h0;
    step(); expect_out(0, 32'hDEADBEEF, 8'h3C, 8'h5A, 3'd0, 1'b0);
    step(); expect_out(0, 32'hDEADBEEF, 8'h3C, 8'h5A, 3'd0, 1'b0);

    // Load under freeze: captured, but shown only after freeze drops.
    freeze = 1'b1; en = 1'b1; data0 = 32'hCAFEF00D;
    step(); expect_out(0, 32'hDEADBEEF, 8'h3C, 8'h5A, 3'd0, 1'b0);
    en = 1'b0;
    step(); expect_out(0, 32'hDEADBEEF, 8'h3C, 8'h5A, 3'd0, 1'b0);
    freeze = 1'b0;
    step(); expect_out(0, 32'hCAFEF00D, 8'h3C, 8'h5A, 3'd0, 1'b0);

    // Auto scan from channel 6: 6,7,0,1 every 4 cycles; Test ignored.
    test = 3'd6;
    step(); expect_out(0, 32'h66666666, 8'h16, 8'h26, 3'd6, 1'b0);
    auto_m = 1'b1;
    step(); expect_out(0, 32'h66666666, 8'h16, 8'h26, 3'd6, 1'b0);
    test = 3'd2;
    repeat (3) begin step(); expect_out(0, 32'h66666666, 8'h16, 8'h26, 3'd6, 1'b0); end
    step(); expect_out(0, 32'h77777777, 8'h17, 8'h27, 3'd7, 1'b1);
    repeat (3) begin step(); expect_out(0, 32'h77777777, 8'h17, 8'h27, 3'd7, 1'b0); end
    // EN coincident with the wrap to channel 0: both take effect.
    en = 1'b1; data0 = 32'h0BADC0DE;
    step(); expect_out(0, 32'hCAFEF00D, 8'h3C, 8'h5A, 3'd0, 1'b1);
    en = 1'b0;
    repeat (3) begin step(); expect_out(0, 32'h0BADC0DE, 8'h3C, 8'h5A, 3'd0, 1'b0); end
    step(); expect_out(0, 32'h11111111, 8'h11, 8'h21, 3'd1, 1'b1);
    repeat (3) begin step(); expect_out(0, 32'h11111111, 8'h11, 8'h21, 3'd1, 1'b0); end

    // auto drops on a terminal-count cycle: manual wins, no tick.
    auto_m = 1'b0;
    step(); expect_out(0, 32'h22222222, 8'h12, 8'h22, 3'd2, 1'b0);

    // Mode change deferred by freeze; scan then starts from channel 2.
    freeze = 1'b1; auto_m = 1'b1; test = 3'd5;
    step(); expect_out(0, 32'h22222222, 8'h12, 8'h22, 3'd2, 1'b0);
    step(); expect_out(0, 32'h22222222, 8'h12, 8'h22, 3'd2, 1'b0);
    freeze = 1'b0;
    repeat (4) begin step(); expect_out(0, 32'h22222222, 8'h12, 8'h22, 3'd2, 1'b0); end
    step(); expect_out(0, 32'h12345678, 8'h0F, 8'hA0, 3'd3, 1'b1);
    repeat (2) begin step(); expect_out(0, 32'h12345678, 8'h0F, 8'hA0, 3'd3, 1'b0); end

    // Reset mid-scan with the counter at 2.
    rst = 1'b0;
    step();
    expect_out(0, 32'hAA5555AA, 8'hFF, 8'h00, 3'd0, 1'b0);
    expect_out(1, 32'hAA5555AA, 8'hFF, 8'h00, 3'd0, 1'b0);
    rst = 1'b1; auto_m = 1'b0; test = 3'd4;
    step(); expect_out(0, 32'h44444444, 8'h14, 8'h24, 3'd4, 1'b0);

    // Drain: anything still queued was never compared.
    repeat (2) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
